// File: rtl/pht_pkg.sv
// Shared types, defaults and the saturating confidence update for the PHT updater.
package pht_pkg;

  localparam int unsigned TAG_W_DEF   = 27;
  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned COUNT_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } pht_state_e;

  // Saturating up/down counter step; width must be below 32.
  function automatic logic [31:0] pht_next_conf(input logic [31:0] old_v,
                                                input logic        taken,
                                                input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (taken && (old_v < max_v)) begin
      pht_next_conf = old_v + 32'd1;
    end else if (!taken && (old_v != 32'd0)) begin
      pht_next_conf = old_v - 32'd1;
    end else begin
      pht_next_conf = old_v;
    end
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Pending-update FIFO holding {index, taken, pred_taken}; DEPTH must be a power of two.
module pht_upd_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     push_in,
  input  logic [WIDTH-1:0]         push_data_in,
  input  logic                     pop_in,
  output logic [WIDTH-1:0]         head_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full_out  = (r_count == CNT_W'(DEPTH));
  assign empty_out = (r_count == '0);
  assign count_out = r_count;
  assign head_out  = r_mem[r_rd_ptr];
  assign w_push    = push_in & ~full_out;
  assign w_pop     = pop_in & ~empty_out;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pht_updater.sv
// Queues resolved branches and applies read-modify-write updates to the PHT.
// Optional statistics counters are enabled by defining PHT_UPD_STATS_EN.
module pht_updater
  import pht_pkg::*;
#(
  parameter int unsigned TAG   = TAG_W_DEF,
  parameter int unsigned PC    = PC_W_DEF,
  parameter int unsigned COUNT = COUNT_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                resolve_valid_in,
  output logic                resolve_ready_out,
  input  logic [PC-1:0]       resolve_pc_in,
  input  logic                resolve_taken_in,
  input  logic                resolve_pred_taken_in,
  output logic [PC-TAG-1:0]   pht_index_out,
  input  logic [COUNT-1:0]    pht_confidence_in,
  output logic                pht_update_out,
  output logic [COUNT-1:0]    pht_new_confidence_out,
`ifdef PHT_UPD_STATS_EN
  output logic [15:0]         update_count_out,
  output logic [15:0]         mispredict_count_out,
`endif
  output logic                busy_out
);

  localparam int unsigned IDX_W = PC - TAG;
  localparam int unsigned ENT_W = IDX_W + 2;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  pht_state_e       r_state;
  pht_state_e       w_state_nxt;
  logic [COUNT-1:0] r_conf;
  logic [COUNT-1:0] w_next_conf;
  logic [ENT_W-1:0] w_push_data;
  logic [ENT_W-1:0] w_head;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_taken;
  logic             w_head_pred;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_push;
  logic             w_pop;
  logic             w_conf_load;
  logic             w_unused;

  assign resolve_ready_out = ~w_full;
  assign w_push            = resolve_valid_in & resolve_ready_out;
  assign w_push_data       = {resolve_pc_in[IDX_W+1:2], resolve_taken_in, resolve_pred_taken_in};
  assign w_head_idx        = w_head[ENT_W-1:2];
  assign w_head_taken      = w_head[1];
  assign w_head_pred       = w_head[0];
  assign w_next_conf       = COUNT'(pht_next_conf(32'(r_conf), w_head_taken, COUNT));
  assign busy_out          = ~w_empty | (r_state != ST_IDLE);
  assign w_unused          = ^{resolve_pc_in[PC-1:IDX_W+2], resolve_pc_in[1:0], w_head_pred};

  pht_upd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .push_in      (w_push),
    .push_data_in (w_push_data),
    .pop_in       (w_pop),
    .head_out     (w_head),
    .full_out     (w_full),
    .empty_out    (w_empty),
    .count_out    (w_count)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The write lands before the next READ, so same-index records chain correctly.
  always_comb begin
    w_state_nxt            = r_state;
    pht_update_out         = 1'b0;
    pht_index_out          = '0;
    pht_new_confidence_out = '0;
    w_pop                  = 1'b0;
    w_conf_load            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        pht_index_out = w_head_idx;
        w_conf_load   = 1'b1;
        w_state_nxt   = ST_WRITE;
      end
      ST_WRITE: begin
        pht_update_out         = 1'b1;
        pht_index_out          = w_head_idx;
        pht_new_confidence_out = w_next_conf;
        w_pop                  = 1'b1;
        w_state_nxt            = ((w_count > CNT_W'(1)) || w_push) ? ST_READ : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_conf <= '0;
    end else if (w_conf_load) begin
      r_conf <= pht_confidence_in;
    end
  end

`ifdef PHT_UPD_STATS_EN
  logic [15:0] r_upd_cnt;
  logic [15:0] r_misp_cnt;

  assign update_count_out     = r_upd_cnt;
  assign mispredict_count_out = r_misp_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_upd_cnt  <= '0;
      r_misp_cnt <= '0;
    end else if (r_state == ST_WRITE) begin
      if (r_upd_cnt != 16'hFFFF) r_upd_cnt <= r_upd_cnt + 16'd1;
      if ((w_head_taken != w_head_pred) && (r_misp_cnt != 16'hFFFF)) begin
        r_misp_cnt <= r_misp_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pht_updater.md
PHT_UPDATER -- requirements
Module: pht_updater

Interface
REQ-001 SHALL have parameter TAG, default 27, meaning tag width; index width is PC-TAG.
REQ-002 SHALL have parameter PC, default 32, meaning PC width.
REQ-003 SHALL have parameter COUNT, default 2, meaning confidence counter width.
REQ-004 SHALL have parameter DEPTH, default 4, meaning pending-update FIFO depth (power of two, >=2).
REQ-005 SHALL have port clk_in, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n_in, input, 1, synchronous active-low reset.
REQ-007 SHALL have port resolve_valid_in, input, 1, resolved-branch record valid.
REQ-008 SHALL have port resolve_ready_out, output, 1, record accepted when valid and ready are both high at a rising edge.
REQ-009 SHALL have port resolve_pc_in, input, PC, branch PC.
REQ-010 SHALL have port resolve_taken_in, input, 1, actual branch outcome.
REQ-011 SHALL have port resolve_pred_taken_in, input, 1, direction predicted at fetch.
REQ-012 SHALL have port pht_index_out, output, PC-TAG, PHT read/write index.
REQ-013 SHALL have port pht_confidence_in, input, COUNT, combinational PHT read data for pht_index_out.
REQ-014 SHALL have port pht_update_out, output, 1, PHT write enable.
REQ-015 SHALL have port pht_new_confidence_out, output, COUNT, PHT write data.
REQ-016 SHALL have port busy_out, output, 1, high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-017 Index SHALL be resolve_pc_in[PC-TAG+1:2], captured at acceptance.
REQ-018 resolve_ready_out SHALL be high exactly when the FIFO holds fewer than DEPTH entries; there is no bypass when full.
REQ-019 FSM states SHALL be IDLE, READ, WRITE; IDLE->READ when the FIFO is non-empty; READ->WRITE unconditionally; WRITE->READ if the FIFO still holds entries after the pop, else IDLE.
REQ-020 In READ, pht_index_out SHALL carry the head index and the unit SHALL register pht_confidence_in at the end of the cycle.
REQ-021 In WRITE, pht_update_out SHALL be 1, pht_index_out SHALL hold the head index, pht_new_confidence_out SHALL hold the next value, and the head SHALL pop at the end of the cycle.
REQ-022 Next value SHALL be computed as follows: taken and old < 2**COUNT-1 gives old+1; not taken and old > 0 gives old-1; otherwise old.
REQ-023 pht_update_out SHALL be 0 in all states other than WRITE; each accepted record produces exactly one write, in acceptance order.
REQ-024 Back-to-back records to the same index SHALL each see the previous record's written value, because the write completes before the next READ.
REQ-025 A push and a pop in the same cycle SHALL leave the occupancy unchanged.

Reset
REQ-026 While rst_n_in is low at a rising edge: FIFO empty, FSM IDLE, registered confidence 0, and pht_update_out, pht_index_out, pht_new_confidence_out all 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending records with no PHT write in the following cycle; resolve_ready_out SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 With PHT_UPD_STATS_EN defined, the module SHALL add output ports update_count_out[15:0] and mispredict_count_out[15:0].
REQ-029 update_count_out SHALL increment once per WRITE cycle, saturating at 16'hFFFF.
REQ-030 mispredict_count_out SHALL increment in a WRITE cycle when the head's taken differs from its pred_taken, saturating at 16'hFFFF.
REQ-031 Both counters SHALL be reset to 0 by rst_n_in.
REQ-032 Without PHT_UPD_STATS_EN, the statistics ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package pht_pkg SHALL hold the FSM state enum, the default TAG/PC/COUNT values, and the saturating next-value function.
REQ-034 The FIFO SHALL be a sub-module named pht_upd_fifo (push/pop, full/empty, DEPTH entries of {index, taken, pred_taken}).

Verification
REQ-035 Single record: PC 0x00000014, taken, PHT entry 5 = 2'b01 -> READ then WRITE with index 5, new value 2'b10; IDLE after 3 cycles.
REQ-036 Saturation: entry 3 = 2'b11 with taken -> writes 2'b11; entry 3 = 2'b00 with not-taken -> writes 2'b00.
REQ-037 Four taken records to index 7 issued back-to-back from 2'b00 -> successive writes 01, 10, 11, 11; ready low while 4 entries are pending.
REQ-038 Full FIFO: with valid held high, ready deasserts after DEPTH accepts and no record is lost; writes emerge in order.
REQ-039 Reset asserted during a WRITE with 2 records pending -> no further pht_update_out, busy_out 0, ready 1 after release.
REQ-040 With PHT_UPD_STATS_EN defined: 3 records, 1 mispredicted -> update_count_out 3, mispredict_count_out 1.
